// File: rtl/updown_cnt_scheduler_if.sv
// rtl/updown_cnt_scheduler_if.sv - requester/status bundle for the shared up/down counter scheduler
`timescale 1ns/1ps

interface updown_cnt_scheduler_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]       req_valid;
    logic [2*NREQ-1:0]     req_op;
    logic [WIDTH*NREQ-1:0] req_data;
    logic                  fault_clr;
    logic [NREQ-1:0]       req_ack;
    logic                  resp_err;
    logic [WIDTH-1:0]      count;
    logic [IDW-1:0]        grant_id;
    logic                  busy;
    logic                  overflow;
    logic                  underflow;

    // requester / control-agent side
    modport master (
        output req_valid, req_op, req_data, fault_clr,
        input  req_ack, resp_err, count, grant_id, busy, overflow, underflow
    );

    // scheduler side
    modport slave (
        input  req_valid, req_op, req_data, fault_clr,
        output req_ack, resp_err, count, grant_id, busy, overflow, underflow
    );
endinterface

// File: rtl/updown_cnt_scheduler.sv
// rtl/updown_cnt_scheduler.sv - round-robin shared up/down counter; CNT_SAT_EN selects saturate instead of sticky FAULT
`timescale 1ns/1ps

module updown_cnt_scheduler #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    updown_cnt_scheduler_if.slave   bus
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0]       OP_READ = 2'b00;
    localparam logic [1:0]       OP_UP   = 2'b01;
    localparam logic [1:0]       OP_DOWN = 2'b10;
    localparam logic [1:0]       OP_LOAD = 2'b11;
    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_MIN = '0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARB   = 2'd1,
        S_EXEC  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] count_q, count_nx;
    logic [NREQ-1:0]  ack_q, ack_nx;
    logic             err_q, err_nx;
    logic [IDW-1:0]   grant_q, grant_nx;
    logic [IDW-1:0]   rr_q, rr_nx;
    logic             ovf_q, ovf_nx;
    logic             unf_q, unf_nx;

    logic [IDW-1:0]   arb_win;
    logic             arb_found;
    int               arb_best;
    int               arb_dist;

    logic             cur_valid;
    logic [1:0]       cur_op;
    logic [WIDTH-1:0] cur_data;

    // Round-robin pick: the valid requester closest after rr_q (wrapping) wins.
    always_comb begin
        arb_win   = rr_q;
        arb_found = 1'b0;
        arb_best  = NREQ;
        arb_dist  = 0;
        for (int i = 0; i < NREQ; i++) begin
            arb_dist = (i + NREQ - 1 - int'(rr_q)) % NREQ;
            if (bus.req_valid[i] && (arb_dist < arb_best)) begin
                arb_best  = arb_dist;
                arb_win   = IDW'(i);
                arb_found = 1'b1;
            end
        end
    end

    // Mux the latched winner's valid/op/data; these are re-read live in EXEC.
    always_comb begin
        cur_valid = 1'b0;
        cur_op    = OP_READ;
        cur_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q == IDW'(i)) begin
                cur_valid = bus.req_valid[i];
                cur_op    = bus.req_op[2*i +: 2];
                cur_data  = bus.req_data[WIDTH*i +: WIDTH];
            end
        end
    end

    // Next-state and next-datapath values for the IDLE/ARB/EXEC/FAULT sequence.
    always_comb begin
        state_nx = state;
        count_nx = count_q;
        ack_nx   = '0;
        err_nx   = 1'b0;
        grant_nx = grant_q;
        rr_nx    = rr_q;
`ifdef CNT_SAT_EN
        ovf_nx   = 1'b0;
        unf_nx   = 1'b0;
`else
        ovf_nx   = ovf_q;
        unf_nx   = unf_q;
`endif
        case (state)
            S_IDLE: begin
                if (|bus.req_valid) state_nx = S_ARB;
            end
            S_ARB: begin
                if (arb_found) begin
                    grant_nx = arb_win;
                    rr_nx    = arb_win;
                    state_nx = S_EXEC;
                end else begin
                    state_nx = S_IDLE;
                end
            end
            S_EXEC: begin
                state_nx = S_IDLE;
                if (cur_valid) begin
                    for (int i = 0; i < NREQ; i++) ack_nx[i] = (grant_q == IDW'(i));
                    case (cur_op)
                        OP_UP: begin
                            if (count_q == CNT_MAX) begin
                                err_nx = 1'b1;
                                ovf_nx = 1'b1;
`ifndef CNT_SAT_EN
                                state_nx = S_FAULT;
`endif
                            end else begin
                                count_nx = count_q + 1'b1;
                            end
                        end
                        OP_DOWN: begin
                            if (count_q == CNT_MIN) begin
                                err_nx = 1'b1;
                                unf_nx = 1'b1;
`ifndef CNT_SAT_EN
                                state_nx = S_FAULT;
`endif
                            end else begin
                                count_nx = count_q - 1'b1;
                            end
                        end
                        OP_LOAD: count_nx = cur_data;
                        default: count_nx = count_q;
                    endcase
                end
            end
            S_FAULT: begin
`ifdef CNT_SAT_EN
                state_nx = S_IDLE;
`else
                if (bus.fault_clr) begin
                    state_nx = S_IDLE;
                    ovf_nx   = 1'b0;
                    unf_nx   = 1'b0;
                end
`endif
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    // Counter, ack/response, grant bookkeeping and range flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            ack_q   <= '0;
            err_q   <= 1'b0;
            grant_q <= '0;
            rr_q    <= IDW'(NREQ - 1);
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_nx;
            ack_q   <= ack_nx;
            err_q   <= err_nx;
            grant_q <= grant_nx;
            rr_q    <= rr_nx;
            ovf_q   <= ovf_nx;
            unf_q   <= unf_nx;
        end
    end

`ifdef CNT_SAT_EN
    logic unused_fault_clr;
    assign unused_fault_clr = bus.fault_clr;
`endif

    assign bus.req_ack   = ack_q;
    assign bus.resp_err  = err_q;
    assign bus.count     = count_q;
    assign bus.grant_id  = grant_q;
    assign bus.busy      = (state == S_ARB) || (state == S_EXEC);
    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;

endmodule

// File: tb/tb_updown_cnt_scheduler.sv
// tb/tb_updown_cnt_scheduler.sv - self-checking bench for updown_cnt_scheduler (CNT_SAT_EN aware)
`timescale 1ns/1ps

module tb_updown_cnt_scheduler;
    localparam int NREQ  = 4;
    localparam int WIDTH = 4;
    localparam int MAXV  = 15;

    logic clk;
    logic reset;

    updown_cnt_scheduler_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

    updown_cnt_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    bit chk_en = 0;

    // transaction-level model: timestamps of pending arbitration/execution
    int m_count = 0;
    int m_rr    = NREQ - 1;
    int m_grant = 0;
    int m_ack   = 0;
    int m_err   = 0;
    int m_ovf   = 0;
    int m_unf   = 0;
    int m_pend  = 0;
    int m_fault = 0;
    int m_arb_at  = 0;
    int m_exec_at = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: actual=%0d required=%0d", nm, cyc, act, exp);
        end
    endtask

    always @(posedge clk) begin
        int op;
        int data;
        int w;
        cyc++;
        m_ack = 0;
        m_err = 0;
`ifdef CNT_SAT_EN
        m_ovf = 0;
        m_unf = 0;
`endif
        if (reset) begin
            m_count = 0; m_rr = NREQ - 1; m_grant = 0;
            m_ovf = 0; m_unf = 0; m_pend = 0; m_fault = 0;
        end else if (m_fault != 0) begin
            if (bus.fault_clr) begin
                m_fault = 0; m_ovf = 0; m_unf = 0;
            end
        end else if (m_pend != 0 && cyc == m_exec_at) begin
            m_pend = 0;
            if (bus.req_valid[m_grant]) begin
                op   = int'((bus.req_op >> (2 * m_grant)) & 8'h3);
                data = int'((bus.req_data >> (WIDTH * m_grant)) & 16'hF);
                m_ack = 1 << m_grant;
                if (op == 1) begin
                    if (m_count == MAXV) begin
                        m_err = 1; m_ovf = 1;
`ifndef CNT_SAT_EN
                        m_fault = 1;
`endif
                    end else m_count = m_count + 1;
                end else if (op == 2) begin
                    if (m_count == 0) begin
                        m_err = 1; m_unf = 1;
`ifndef CNT_SAT_EN
                        m_fault = 1;
`endif
                    end else m_count = m_count - 1;
                end else if (op == 3) begin
                    m_count = data;
                end
            end
        end else if (m_pend != 0 && cyc == m_arb_at) begin
            w = -1;
            for (int k = 1; k <= NREQ; k++) begin
                if (w < 0 && bus.req_valid[(m_rr + k) % NREQ]) w = (m_rr + k) % NREQ;
            end
            if (w < 0) m_pend = 0;
            else begin
                m_grant = w; m_rr = w;
            end
        end else if (m_pend == 0 && bus.req_valid != 0) begin
            m_pend = 1; m_arb_at = cyc + 1; m_exec_at = cyc + 2;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ack",       int'(bus.req_ack),   m_ack);
            chk("count",     int'(bus.count),     m_count);
            chk("resp_err",  int'(bus.resp_err),  m_err);
            chk("grant_id",  int'(bus.grant_id),  m_grant);
            chk("busy",      int'(bus.busy),      m_pend);
            chk("overflow",  int'(bus.overflow),  m_ovf);
            chk("underflow", int'(bus.underflow), m_unf);
        end
    end

    // wait for an ack from requester i (-1 = any); who = acked index, at = cycle
    task automatic wait_ack(input int i, input string nm, output int who, output int at);
        who = -1;
        at  = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.req_ack != 0 && (i < 0 || bus.req_ack[i])) begin
                at = cyc;
                for (int b = 0; b < NREQ; b++) if (bus.req_ack[b]) who = b;
                break;
            end
        end
        if (at < 0) begin
            checks++;
            errors++;
            $display("FAIL %s: no ack within 40 cycles (actual=none required=ack)", nm);
        end
    endtask

    task automatic do_reset();
        bus.req_valid = '0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int who;
        int at;
        int n;
        int base;
        int exp3 [6];
        exp3 = '{0, 1, 3, 0, 1, 3};

        reset         = 1'b1;
        bus.req_valid = '0;
        bus.req_op    = '0;
        bus.req_data  = '0;
        bus.fault_clr = 1'b0;

        // T1: reset held two cycles with all requesters asking
        bus.req_valid = 4'hF;
        bus.req_op    = 8'b01_01_01_01;
        @(negedge clk);
        chk_en = 1;
        @(negedge clk);
        chk("t1_count", int'(bus.count), 0);
        chk("t1_ack", int'(bus.req_ack), 0);
        chk("t1_busy", int'(bus.busy), 0);
        chk("t1_grant", int'(bus.grant_id), 0);
        chk("t1_ovf", int'(bus.overflow), 0);
        reset = 1'b0;
        base  = cyc;
        wait_ack(-1, "t1_wait", who, at);
        chk("t1_latency", at - base, 3);
        chk("t1_first_winner", who, 0);
        do_reset();

        // T2: req0 UP three times, held continuously
        bus.req_op       = 8'b00_00_00_01;
        bus.req_valid[0] = 1'b1;
        n = cyc + 1;
        for (int k = 0; k < 3; k++) begin
            wait_ack(0, "t2_wait", who, at);
            chk("t2_ack_cycle", at, n + 2 + 3 * k);
            chk("t2_count", int'(bus.count), k + 1);
            chk("t2_resp_err", int'(bus.resp_err), 0);
        end
        do_reset();

        // T3: round robin over 4'b1011, all UP
        bus.req_op    = 8'b01_01_01_01;
        bus.req_valid = 4'b1011;
        for (int k = 0; k < 6; k++) begin
            wait_ack(-1, "t3_wait", who, at);
            chk("t3_order", who, exp3[k]);
            chk("t3_count", int'(bus.count), k + 1);
        end
        do_reset();

`ifndef CNT_SAT_EN
        // T4: load max, UP overflows into FAULT, pending DOWN waits for fault_clr
        bus.req_op[5:4]    = 2'b11;
        bus.req_data[11:8] = 4'hF;
        bus.req_valid[2]   = 1'b1;
        wait_ack(2, "t4_load", who, at);
        chk("t4_load_count", int'(bus.count), 15);
        bus.req_op[5:4] = 2'b01;
        wait_ack(2, "t4_up", who, at);
        chk("t4_err", int'(bus.resp_err), 1);
        chk("t4_ovf", int'(bus.overflow), 1);
        chk("t4_count_held", int'(bus.count), 15);
        bus.req_valid[2] = 1'b0;
        bus.req_op[3:2]  = 2'b10;
        bus.req_valid[1] = 1'b1;
        n = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.req_ack != 0) n++;
        end
        chk("t4_acks_in_fault", n, 0);
        chk("t4_ovf_sticky", int'(bus.overflow), 1);
        bus.fault_clr = 1'b1;
        @(negedge clk);
        bus.fault_clr = 1'b0;
        chk("t4_ovf_cleared", int'(bus.overflow), 0);
        wait_ack(1, "t4_down", who, at);
        chk("t4_down_count", int'(bus.count), 14);
        chk("t4_down_err", int'(bus.resp_err), 0);
        do_reset();
`else
        // T5: DOWN at zero saturates with a one-cycle underflow pulse
        bus.req_op[1:0]  = 2'b10;
        bus.req_valid[0] = 1'b1;
        wait_ack(0, "t5_down", who, at);
        chk("t5_err", int'(bus.resp_err), 1);
        chk("t5_unf", int'(bus.underflow), 1);
        chk("t5_count", int'(bus.count), 0);
        bus.req_op[1:0] = 2'b01;
        @(negedge clk);
        chk("t5_unf_pulse", int'(bus.underflow), 0);
        wait_ack(0, "t5_up", who, at);
        chk("t5_up_count", int'(bus.count), 1);
        chk("t5_up_err", int'(bus.resp_err), 0);
        do_reset();
`endif

        // T6: reset lands in the EXEC cycle of req3 UP
        bus.req_op       = 8'b01_00_00_01;
        bus.req_valid[3] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t6_busy_exec", int'(bus.busy), 1);
        reset = 1'b1;
        @(negedge clk);
        chk("t6_no_ack", int'(bus.req_ack), 0);
        chk("t6_count", int'(bus.count), 0);
        bus.req_valid[0] = 1'b1;
        reset = 1'b0;
        wait_ack(-1, "t6_first", who, at);
        chk("t6_first_winner", who, 0);
        bus.req_valid[0] = 1'b0;
        wait_ack(-1, "t6_second", who, at);
        chk("t6_second_winner", who, 3);
        chk("t6_count_after", int'(bus.count), 2);
        bus.req_valid = '0;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (actual=timeout required=finish)");
        $fatal(1);
    end

endmodule
